// File: rtl/bru_issue_queue.sv
// bru_issue_queue: age-ordered collapsing issue queue feeding the single BRU execute pipe.
// Ports:
//   clk, reset        clock; synchronous active-high reset
//   flush             kills every entry and blocks issue/dispatch this cycle
//   disp_*            dispatch handshake (disp_valid/disp_ready), ROB index, two source tags
//                     with ready bits, opaque payload
//   wake_valid/tag    WAKE_N result-tag broadcast ports, port k at wake_tag[k*TAG_W +: TAG_W]
//   iss_*             issued op (no backpressure), zero when nothing issues
//   count             number of occupied slots
// Build option: define BRU_IQ_IN_ORDER_EN to restrict issue to the head slot (program order).
module bru_issue_queue #(
    parameter int DEPTH     = 4,
    parameter int TAG_W     = 6,
    parameter int ROB_W     = 4,
    parameter int PAYLOAD_W = 128,
    parameter int WAKE_N    = 3,
    localparam int CW       = $clog2(DEPTH + 1),
    localparam int IW       = $clog2(DEPTH)
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    flush,
    input  logic                    disp_valid,
    output logic                    disp_ready,
    input  logic [ROB_W-1:0]        disp_rob,
    input  logic [TAG_W-1:0]        disp_src1_tag,
    input  logic                    disp_src1_rdy,
    input  logic [TAG_W-1:0]        disp_src2_tag,
    input  logic                    disp_src2_rdy,
    input  logic [PAYLOAD_W-1:0]    disp_payload,
    input  logic [WAKE_N-1:0]       wake_valid,
    input  logic [WAKE_N*TAG_W-1:0] wake_tag,
    output logic                    iss_valid,
    output logic [ROB_W-1:0]        iss_rob,
    output logic [PAYLOAD_W-1:0]    iss_payload,
    output logic [CW-1:0]           count
);
    typedef struct packed {
        logic                 valid;
        logic [ROB_W-1:0]     rob;
        logic [TAG_W-1:0]     t1;
        logic                 r1;
        logic [TAG_W-1:0]     t2;
        logic                 r2;
        logic [PAYLOAD_W-1:0] payload;
    } entry_t;

    entry_t         q [DEPTH];
    entry_t         q_next [DEPTH];
    entry_t         e;
    logic [DEPTH-1:0] elig;
    logic [IW-1:0]  sel;
    logic [CW-1:0]  count_next, wr_idx;
    logic           accept;

    function automatic logic woke(input logic [TAG_W-1:0] t, input logic [WAKE_N-1:0] v,
                                  input logic [WAKE_N*TAG_W-1:0] tags);
        woke = 1'b0;
        for (int k = 0; k < WAKE_N; k++)
            woke |= v[k] && (tags[k*TAG_W +: TAG_W] == t);
    endfunction

    assign disp_ready = (count < CW'(DEPTH)) && !flush;

    // Select works from registered state only, so a wakeup is seen one cycle later.
    always_comb begin
        elig = '0;
        for (int i = 0; i < DEPTH; i++)
            elig[i] = q[i].valid && q[i].r1 && q[i].r2;
`ifdef BRU_IQ_IN_ORDER_EN
        elig[DEPTH-1:1] = '0;
`endif
        sel = '0;
        for (int i = DEPTH - 1; i >= 0; i--)
            if (elig[i]) sel = IW'(i);
        iss_valid   = (|elig) && !flush;
        iss_rob     = iss_valid ? q[sel].rob : '0;
        iss_payload = iss_valid ? q[sel].payload : '0;
    end

    // Compact above the issued slot, apply wakeups, then write the new op at the tail.
    always_comb begin
        accept     = disp_valid && disp_ready;
        wr_idx     = count - CW'(iss_valid);
        count_next = count + CW'(accept) - CW'(iss_valid);
        e          = '0;
        for (int i = 0; i < DEPTH; i++) begin
            e = (iss_valid && IW'(i) >= sel) ? q[(i + 1) % DEPTH] : q[i];
            if (iss_valid && IW'(i) >= sel && i == DEPTH - 1) e.valid = 1'b0;
            e.r1 = e.r1 | woke(e.t1, wake_valid, wake_tag);
            e.r2 = e.r2 | woke(e.t2, wake_valid, wake_tag);
            if (accept && wr_idx == CW'(i))
                e = '{1'b1, disp_rob,
                      disp_src1_tag, disp_src1_rdy | woke(disp_src1_tag, wake_valid, wake_tag),
                      disp_src2_tag, disp_src2_rdy | woke(disp_src2_tag, wake_valid, wake_tag),
                      disp_payload};
            q_next[i] = e;
        end
    end

    always_ff @(posedge clk) begin
        if (reset || flush) begin
            count <= '0;
            for (int i = 0; i < DEPTH; i++) q[i] <= '0;
        end else begin
            count <= count_next;
            q     <= q_next;
        end
    end
endmodule
